tm1638_key_mapper: RTL

Parametrised key-to-display stimulus block for the TM1638 driver. Takes raw key-scan words read over SPI, optionally debounces them, detects press edges, and maintains a display image (segments + LEDs) in one of three modes (mirror, toggle, count). It hands each changed image to the driver over a valid/ready handshake instead of a free-running pulse.

---
 rtl/tm1638_key_mapper.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/tm1638_key_mapper.sv
// tm1638_key_mapper: turns raw TM1638 key-scan words into a display image
// (segments + LEDs) in MIRROR / TOGGLE / COUNT mode. Each changed image is
// offered to the driver on a valid/ready handshake. All state updates on the
// falling edge of i_Clk; i_Rst is synchronous, active-high.
// Optional feature: define TM1638_KEYS_DEBOUNCE_EN to insert a per-key
// debouncer requiring DEBOUNCE_SAMPLES equal consecutive samples.

`ifdef TM1638_KEYS_DEBOUNCE_EN
// One key lane: tracks a candidate level and how many valid samples in a row
// agreed with it; reports the accepted level for this edge.
module tm1638_key_debounce #(
    parameter int SAMPLES = 3
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Sample,
    input  logic i_Raw,
    input  logic i_Stable,
    output logic o_Stable_d
);
    logic       cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;

    // next candidate/count, and the level accepted on this sample
    always_comb begin
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        o_Stable_d = i_Stable;
        if (i_Sample) begin
            if (i_Raw == cand_q) begin
                cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cand_d = i_Raw;
                cnt_d  = 4'd1;
            end
            if (cnt_d >= 4'(SAMPLES)) o_Stable_d = cand_d;
        end
    end

    // candidate and run-length registers
    always_ff @(negedge i_Clk) begin
        if (i_Rst) begin
            cand_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule
`endif

module tm1638_key_mapper #(
    parameter int NUM_GRIDS        = 8,
    parameter int SPI_READ_WIDTH   = 32,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic [SPI_READ_WIDTH-1:0] i_Data,
    input  logic                      i_Data_Valid,
    input  logic [1:0]                i_Mode,
    input  logic                      i_Ready,
    output logic [NUM_GRIDS*8-1:0]    o_Segments,
    output logic [NUM_GRIDS-1:0]      o_Leds,
    output logic                      o_Valid
);
    localparam int STRIDE = SPI_READ_WIDTH / NUM_GRIDS;
    localparam logic [1:0] MODE_TOGGLE = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;

    typedef enum logic [1:0] {IDLE, APPLY, SEND} state_t;

    state_t                          state_q, state_d;
    logic [NUM_GRIDS-1:0]            raw_keys;
    logic [NUM_GRIDS-1:0]            stable_q, stable_d;
    logic [NUM_GRIDS-1:0]            pend_q, pend_d;     // presses not yet applied
    logic                            chg_q, chg_d;       // image needs refresh
    logic [NUM_GRIDS-1:0]            tog_q, tog_d;
    logic [NUM_GRIDS-1:0][3:0]       ctr_q, ctr_d;
    logic [1:0]                      mode_q, mode_d;
    logic [NUM_GRIDS-1:0][7:0]       seg_q, seg_d;
    logic [NUM_GRIDS-1:0]            led_q, led_d;
    logic                            valid_q, valid_d;

    // Only one bit per key slot of the scan word is meaningful.
    logic unused_data;
    assign unused_data = ^i_Data;

    for (genvar k = 0; k < NUM_GRIDS; k++) begin : g_tap
        assign raw_keys[k] = i_Data[k*STRIDE];
    end

`ifdef TM1638_KEYS_DEBOUNCE_EN
    for (genvar k = 0; k < NUM_GRIDS; k++) begin : g_db
        tm1638_key_debounce #(.SAMPLES(DEBOUNCE_SAMPLES)) u_db (
            .i_Clk      (i_Clk),
            .i_Rst      (i_Rst),
            .i_Sample   (i_Data_Valid),
            .i_Raw      (raw_keys[k]),
            .i_Stable   (stable_q[k]),
            .o_Stable_d (stable_d[k])
        );
    end
`else
    // Without debounce every fresh scan is taken at face value.
    logic unused_cfg;
    assign unused_cfg = (DEBOUNCE_SAMPLES != 0);
    assign stable_d   = i_Data_Valid ? raw_keys : stable_q;
`endif

    // 7-segment hex glyphs, bit0=a .. bit6=g, dp clear
    function automatic logic [7:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 8'h3F;  4'h1: hex_font = 8'h06;
            4'h2: hex_font = 8'h5B;  4'h3: hex_font = 8'h4F;
            4'h4: hex_font = 8'h66;  4'h5: hex_font = 8'h6D;
            4'h6: hex_font = 8'h7D;  4'h7: hex_font = 8'h07;
            4'h8: hex_font = 8'h7F;  4'h9: hex_font = 8'h6F;
            4'hA: hex_font = 8'h77;  4'hB: hex_font = 8'h7C;
            4'hC: hex_font = 8'h39;  4'hD: hex_font = 8'h5E;
            4'hE: hex_font = 8'h79;  default: hex_font = 8'h71;
        endcase
    endfunction

    // FSM next state, image build in APPLY, event accumulation, mode changes
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        chg_d   = chg_q;
        tog_d   = tog_q;
        ctr_d   = ctr_q;
        mode_d  = mode_q;
        seg_d   = seg_q;
        led_d   = led_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (chg_q) state_d = APPLY;
            end
            APPLY: begin
                for (int k = 0; k < NUM_GRIDS; k++) begin
                    if (pend_q[k]) begin
                        if (mode_q == MODE_TOGGLE) tog_d[k] = ~tog_q[k];
                        if (mode_q == MODE_COUNT)  ctr_d[k] = ctr_q[k] + 4'd1;
                    end
                end
                for (int k = 0; k < NUM_GRIDS; k++) begin
                    case (mode_q)
                        MODE_TOGGLE: begin
                            led_d[k] = tog_d[k];
                            seg_d[k] = hex_font({3'd0, tog_d[k]});
                        end
                        MODE_COUNT: begin
                            led_d[k] = (ctr_d[k] != 4'd0);
                            seg_d[k] = hex_font(ctr_d[k]);
                        end
                        default: begin
                            led_d[k] = stable_q[k];
                            seg_d[k] = stable_q[k] ? (hex_font(4'(k)) | 8'h80) : 8'h00;
                        end
                    endcase
                end
                pend_d  = '0;
                chg_d   = 1'b0;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (i_Ready) begin
                    valid_d = 1'b0;
                    state_d = chg_q ? APPLY : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // new edges always land in the mask, even on the APPLY edge
        pend_d = pend_d | (stable_d & ~stable_q);
        if (stable_d != stable_q) chg_d = 1'b1;

        // mode switch restarts toggle/count state; shown at the next APPLY
        if (i_Mode != mode_q) begin
            mode_d = i_Mode;
            tog_d  = '0;
            ctr_d  = '0;
            chg_d  = 1'b1;
        end
    end

    // state registers
    always_ff @(negedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= IDLE;
            stable_q <= '0;
            pend_q   <= '0;
            chg_q    <= 1'b0;
            tog_q    <= '0;
            ctr_q    <= '0;
            mode_q   <= 2'd0;
            seg_q    <= '0;
            led_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            chg_q    <= chg_d;
            tog_q    <= tog_d;
            ctr_q    <= ctr_d;
            mode_q   <= mode_d;
            seg_q    <= seg_d;
            led_q    <= led_d;
            valid_q  <= valid_d;
        end
    end

    assign o_Segments = seg_q;
    assign o_Leds     = led_q;
    assign o_Valid    = valid_q;
endmodule
